vga_boot_seq: RTL
=================

Name: vga_boot_seq

Overview:
Parametrised boot/splash sequencer for the VGA output path, in the vga_clock domain. It holds the NES in reset (loading) while the splash ROM is displayed, then switches pixel source from splash ROM to frame RAM on a VGA frame boundary. The switch is aligned to the read-data latency. It gates frame-end pulses to the RAM wrapper and adds a PPU-stall watchdog and a host splash request. It sits between the frame RAM wrapper, the splash ROM and the RAM reader.

Parameters:
PIX_W, 6, pixel/palette-index width of q_ram, q_rom, q
CNT_W, 27, boot counter width; must satisfy BOOT_CYCLES <= 2^CNT_W
BOOT_CYCLES, 134217728, cycles from reset release until sequencer may go live
LOAD_CYCLES, 83886080, cycles from reset release until loading deasserts; must be <= BOOT_CYCLES
RD_LAT, 1, read latency (cycles) of RAM/ROM; source select delayed by this amount
WD_FRAMES, 8, VGA frames without a PPU frame end before fallback; 0 disables watchdog

Ports:
vga_clock  in  1  sole clock
rst_n  in  1  asynchronous active-low reset
vga_frame_end  in  1  single-cycle pulse, end of VGA frame
ppu_frame_end  in  1  single-cycle pulse, end of PPU frame, already synchronised into vga_clock
splash_req  in  1  level; high requests splash display
q_ram  in  PIX_W  frame RAM read data
q_rom  in  PIX_W  splash ROM read data
q  out  PIX_W  selected pixel to RAM reader
vga_frame_end_gated  out  1  vga_frame_end passed only while live
ppu_frame_end_gated  out  1  ppu_frame_end passed only while live
loading  out  1  high holds NES in reset
state  out  2  current state encoding (debug)

Behaviour:
- Reset (async, any time, including mid-frame or mid-count): state=S_BOOT, boot_cnt=0, wd_cnt=0, loading=1, select pipeline all ROM. Outputs: q=q_rom, gated pulses 0, state=0.
- States: S_BOOT=0, S_ARM=1, S_LIVE=2, S_HOLD=3.
- S_BOOT:
  - boot_cnt increments each edge. Edge 1 after reset release gives boot_cnt=1.
  - loading registers 0 on the edge where boot_cnt==LOAD_CYCLES-1, so it is low after edge LOAD_CYCLES.
  - On the edge where boot_cnt==BOOT_CYCLES-1: go to S_ARM; boot_cnt holds (saturates).
  - splash_req is ignored.
- S_ARM:
  - Condition vga_frame_end=1 and splash_req=0: go to S_LIVE next edge.
  - Otherwise stay. The triggering pulse is consumed and not forwarded.
- S_LIVE:
  - Both gated outputs equal their inputs, combinationally.
  - Condition vga_frame_end=1 and splash_req=1: go to S_HOLD.
  - Watchdog expiry (below) has priority over the splash transition.
- S_HOLD:
  - Gated outputs 0; loading unchanged (0).
  - When splash_req=0: go to S_ARM, so return to live is frame-aligned.
- Source select:
  - live_sel = (state==S_LIVE), fed through an RD_LAT-stage register pipeline.
  - q = q_ram when the pipeline output is 1, else q_rom.
  - Reads issued before a switch return data from the matching source.
- Watchdog (S_LIVE only, WD_FRAMES>0):
  - wd_cnt increments on vga_frame_end and clears on ppu_frame_end. If both occur in the same cycle, the clear wins.
  - wd_cnt clears on any exit from S_LIVE.
  - Expiry when wd_cnt==WD_FRAMES-1 and vga_frame_end=1 (no ppu_frame_end): go to S_BOOT, set boot_cnt=0, set loading=1 on the same edge.
  - wd_cnt width is clog2(WD_FRAMES+1).
- Counters never wrap: boot_cnt saturates at BOOT_CYCLES-1; wd_cnt cannot exceed WD_FRAMES-1.
- Latency:
  - State changes take 1 edge.
  - The q source changes RD_LAT edges after the state change.
  - Gated pulses have 0 latency.

Decomposition:
- Package vga_pkg holds:
  - vga_boot_state_t enum (S_BOOT/S_ARM/S_LIVE/S_HOLD, 2 bits)
  - default constants VGA_BOOT_CYCLES and VGA_LOAD_CYCLES
  - a clog2 helper
- One sub-module, vga_frame_watchdog: the wd_cnt counter with enable, clear and expire output, parametrised by WD_FRAMES.

Test Plan:
Bench parameters for all scenarios: BOOT_CYCLES=100, LOAD_CYCLES=60, RD_LAT=1, WD_FRAMES=3, CNT_W=7.
- Boot: release reset, no pulses. loading=1 through edge 59 and 0 after edge 60; state=S_ARM after edge 100; q tracks q_rom (q_rom=0x15, q_ram=0x2A -> q=0x15).
- Frame-aligned switch: in S_ARM, pulse vga_frame_end at cycle 130. Required: vga_frame_end_gated stays 0; state=S_LIVE after edge 131; q=0x2A from edge 132; next vga_frame_end appears on vga_frame_end_gated.
- Splash request: in S_LIVE raise splash_req, no pulse -> stay S_LIVE. Pulse vga_frame_end -> S_HOLD and q=q_rom one edge later. Drop splash_req -> S_ARM; next vga_frame_end -> S_LIVE.
- Watchdog: in S_LIVE send 3 vga_frame_end with no ppu_frame_end. After the 3rd, state=S_BOOT, loading=1, boot_cnt=0, q=q_rom. Repeat with ppu_frame_end coincident with the 2nd vga pulse -> no fallback.
- Reset mid-operation: assert rst_n=0 asynchronously mid-S_LIVE between edges. Outputs go immediately to reset values (loading=1, q=q_rom, state=0) and the boot sequence restarts from count 0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA boot/splash sequencer.
package vga_pkg;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_ARM  = 2'd1,
        S_LIVE = 2'd2,
        S_HOLD = 2'd3
    } vga_boot_state_t;

    localparam int unsigned VGA_BOOT_CYCLES = 134217728;
    localparam int unsigned VGA_LOAD_CYCLES = 83886080;

    // Ceiling log2; returns 0 for values 0 and 1.
    function automatic int unsigned vga_clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/vga_frame_watchdog.sv
// Counts VGA frames without a PPU frame end while enabled; flags expiry on the
// frame that would reach WD_FRAMES. WD_FRAMES=0 disables the watchdog.
module vga_frame_watchdog
    import vga_pkg::*;
#(
    parameter int unsigned WD_FRAMES = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic vga_frame_end_i,
    input  logic ppu_frame_end_i,
    output logic expire_o
);

    localparam int unsigned WdW = (vga_clog2(WD_FRAMES + 1) > 0) ? vga_clog2(WD_FRAMES + 1) : 1;
    localparam logic [WdW-1:0] WdLast = WdW'((WD_FRAMES > 0) ? WD_FRAMES - 1 : 0);

    logic [WdW-1:0] wd_cnt_q, wd_cnt_d;
    logic           expire;

    always_comb begin
        expire   = (WD_FRAMES != 0) && en_i && vga_frame_end_i && !ppu_frame_end_i
                   && (wd_cnt_q == WdLast);
        wd_cnt_d = wd_cnt_q;
        // A PPU frame end in the same cycle as a VGA frame end wins.
        if ((WD_FRAMES == 0) || !en_i || ppu_frame_end_i || expire) begin
            wd_cnt_d = '0;
        end else if (vga_frame_end_i) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end

    assign expire_o = expire;

endmodule

// File: rtl/vga_boot_seq.sv
// Boot/splash sequencer: shows the splash ROM while the NES is held in reset,
// then switches to frame RAM on a VGA frame boundary, aligned to read latency.
module vga_boot_seq
    import vga_pkg::*;
#(
    parameter int unsigned PIX_W       = 6,
    parameter int unsigned CNT_W       = 27,
    parameter int unsigned BOOT_CYCLES = VGA_BOOT_CYCLES,
    parameter int unsigned LOAD_CYCLES = VGA_LOAD_CYCLES,
    parameter int unsigned RD_LAT      = 1,
    parameter int unsigned WD_FRAMES   = 8
) (
    input  logic             vga_clock,
    input  logic             rst_n,
    input  logic             vga_frame_end,
    input  logic             ppu_frame_end,
    input  logic             splash_req,
    input  logic [PIX_W-1:0] q_ram,
    input  logic [PIX_W-1:0] q_rom,
    output logic [PIX_W-1:0] q,
    output logic             vga_frame_end_gated,
    output logic             ppu_frame_end_gated,
    output logic             loading,
    output logic [1:0]       state
);

    localparam logic [CNT_W-1:0] BootLast = CNT_W'(BOOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LoadLast = CNT_W'(LOAD_CYCLES - 1);

    vga_boot_state_t  state_q, state_d;
    logic [CNT_W-1:0] boot_cnt_q, boot_cnt_d;
    logic             loading_q, loading_d;
    logic             live;
    logic             live_sel;
    logic             wd_expire;

    assign live = (state_q == S_LIVE);

    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        loading_d  = loading_q;
        unique case (state_q)
            S_BOOT: begin
                if (boot_cnt_q == LoadLast) begin
                    loading_d = 1'b0;
                end
                if (boot_cnt_q == BootLast) begin
                    state_d = S_ARM;
                end else begin
                    boot_cnt_d = boot_cnt_q + 1'b1;
                end
            end
            S_ARM: begin
                // The arming pulse itself is never forwarded: gating keys off state_q.
                if (vga_frame_end && !splash_req) begin
                    state_d = S_LIVE;
                end
            end
            S_LIVE: begin
                if (wd_expire) begin
                    state_d    = S_BOOT;
                    boot_cnt_d = '0;
                    loading_d  = 1'b1;
                end else if (vga_frame_end && splash_req) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!splash_req) begin
                    state_d = S_ARM;
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge vga_clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_BOOT;
            boot_cnt_q <= '0;
            loading_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            loading_q  <= loading_d;
        end
    end

    // Delay the source select so in-flight reads return from the source they targeted.
    if (RD_LAT == 0) begin : g_no_lat
        assign live_sel = live;
    end else begin : g_lat
        logic [RD_LAT-1:0] sel_q;

        always_ff @(posedge vga_clock or negedge rst_n) begin
            if (!rst_n) begin
                sel_q <= '0;
            end else begin
                sel_q[0] <= live;
                for (int i = 1; i < int'(RD_LAT); i++) begin
                    sel_q[i] <= sel_q[i-1];
                end
            end
        end

        assign live_sel = sel_q[RD_LAT-1];
    end

    vga_frame_watchdog #(
        .WD_FRAMES(WD_FRAMES)
    ) u_watchdog (
        .clk_i          (vga_clock),
        .rst_ni         (rst_n),
        .en_i           (live),
        .vga_frame_end_i(vga_frame_end),
        .ppu_frame_end_i(ppu_frame_end),
        .expire_o       (wd_expire)
    );

    assign q                   = live_sel ? q_ram : q_rom;
    assign vga_frame_end_gated = live & vga_frame_end;
    assign ppu_frame_end_gated = live & ppu_frame_end;
    assign loading             = loading_q;
    assign state               = state_q;

endmodule
